// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// FSM state encoding and access-size / legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    logic [3:0] size;
    case (funct3[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

  function automatic logic is_legal(input logic [2:0] funct3, input logic store,
                                    input int unsigned data_w);
    logic legal;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !store;
      F3_D:             legal = (data_w == 32'd64);
      F3_WU:            legal = !store && (data_w == 32'd64);
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte mask / data shift, alignment check,
// and load-result extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]                 i_addr_lo,
  input  logic [2:0]                 i_funct3,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W/8-1:0]        o_mask,
  output logic [DATA_W-1:0]          o_wdata,
  output logic                       o_misaligned,
  input  logic [$clog2(DATA_W/8)-1:0] i_ld_off,
  input  logic [2:0]                 i_ld_funct3,
  input  logic [DATA_W-1:0]          i_rdata,
  output logic [DATA_W-1:0]          o_ld_data
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(MASK_W);

  logic [OFF_W-1:0]  off_s;
  logic [3:0]        size_s;
  logic [MASK_W-1:0] base_s;
  logic [DATA_W-1:0] sh_s;

  // Store side: lane mask, shifted write data and alignment check.
  always_comb begin
    off_s  = i_addr_lo[OFF_W-1:0];
    size_s = size_bytes(i_funct3);
    base_s = {MASK_W{1'b0}};
    for (int i = 0; i < int'(MASK_W); i++) begin
      base_s[i] = (i < int'(size_s));
    end
    o_mask  = base_s << off_s;
    o_wdata = i_wdata << {off_s, 3'b000};
    case (i_funct3[1:0])
      2'b01:   o_misaligned = i_addr_lo[0];
      2'b10:   o_misaligned = |i_addr_lo[1:0];
      2'b11:   o_misaligned = |i_addr_lo[2:0];
      default: o_misaligned = 1'b0;
    endcase
  end

  // Load side: right-align the addressed lanes, truncate and extend.
  always_comb begin
    sh_s = i_rdata >> {i_ld_off, 3'b000};
    case (i_ld_funct3)
      F3_B:    o_ld_data = DATA_W'($signed(sh_s[7:0]));
      F3_H:    o_ld_data = DATA_W'($signed(sh_s[15:0]));
      F3_W:    o_ld_data = DATA_W'($signed(sh_s[31:0]));
      F3_D:    o_ld_data = sh_s;
      F3_BU:   o_ld_data = DATA_W'(sh_s[7:0]);
      F3_HU:   o_ld_data = DATA_W'(sh_s[15:0]);
      F3_WU:   o_ld_data = DATA_W'(sh_s[31:0]);
      default: o_ld_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Handshaked load/store unit: accepts one access from the core, drives a
// request/grant data memory, waits for the read response and reports done/trap.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned MASK_W = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_trap,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_mask,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned OFF_W   = $clog2(MASK_W);
  localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort on the cycle that makes the trap complete exactly TIMEOUT cycles after accept.
  localparam int unsigned TO_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

  lsu_state_e        state_r, state_s;
  logic              store_r;
  logic [2:0]        funct3_r;
  logic [OFF_W-1:0]  off_r;
  logic [ADDR_W-1:0] addr_r;
  logic [MASK_W-1:0] mask_r;
  logic [DATA_W-1:0] wdata_r;
  logic              trap_r;
  logic [DATA_W-1:0] rdata_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ready_r, done_r, mem_req_r;

  logic              accept_s, bad_s, timeout_s, to_fire_s, mem_req_s;
  logic [MASK_W-1:0] mask_s;
  logic [DATA_W-1:0] wdata_sh_s, ld_data_s;
  logic              misaligned_s;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_addr_lo    (i_addr[2:0]),
    .i_funct3     (i_funct3),
    .i_wdata      (i_wdata),
    .o_mask       (mask_s),
    .o_wdata      (wdata_sh_s),
    .o_misaligned (misaligned_s),
    .i_ld_off     (off_r),
    .i_ld_funct3  (funct3_r),
    .i_rdata      (i_mem_rdata),
    .o_ld_data    (ld_data_s)
  );

  assign accept_s  = i_valid & ready_r;
  assign bad_s     = misaligned_s | !is_legal(i_funct3, i_store, DATA_W);
  assign timeout_s = (TIMEOUT != 0) && (cnt_r >= CNT_W'(TO_LAST));

  // Next-state and next-output decode.
  always_comb begin
    state_s   = state_r;
    to_fire_s = 1'b0;
    mem_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = REQ;
        else          state_s = IDLE;
      end
      // A trapped access spends one cycle here with the request suppressed.
      REQ: begin
        if (trap_r)         state_s = DONE;
        else if (i_mem_gnt) state_s = store_r ? DONE : RESP;
        else if (timeout_s) begin
          state_s   = DONE;
          to_fire_s = 1'b1;
        end else            state_s = REQ;
      end
      RESP: begin
        if (i_mem_rvalid)   state_s = DONE;
        else if (timeout_s) begin
          state_s   = DONE;
          to_fire_s = 1'b1;
        end else            state_s = RESP;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (state_s == REQ) mem_req_s = !(accept_s ? bad_s : trap_r);
    else                mem_req_s = 1'b0;
  end

  // State register and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      mem_req_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ready_r   <= (state_s == IDLE);
      done_r    <= (state_s == DONE);
      mem_req_r <= mem_req_s;
    end
  end

  // Access registers, load result and timeout counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      store_r  <= 1'b0;
      funct3_r <= 3'b000;
      off_r    <= {OFF_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      mask_r   <= {MASK_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      trap_r   <= 1'b0;
      rdata_r  <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            store_r  <= i_store;
            funct3_r <= i_funct3;
            off_r    <= i_addr[OFF_W-1:0];
            addr_r   <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mask_r   <= mask_s;
            wdata_r  <= wdata_sh_s;
            trap_r   <= bad_s;
            rdata_r  <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        REQ, RESP: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (to_fire_s) trap_r <= 1'b1;
          if ((state_r == RESP) && i_mem_rvalid) rdata_r <= ld_data_s;
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = ready_r;
  assign o_done      = done_r;
  assign o_rdata     = rdata_r;
  assign o_trap      = trap_r;
  assign o_mem_req   = mem_req_r;
  assign o_mem_addr  = addr_r;
  assign o_mem_wen   = store_r;
  assign o_mem_wdata = wdata_r;
  assign o_mem_mask  = mask_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a 32-bit unit with an 8-cycle timeout and a
// 64-bit unit without timeout, sharing memory-side stimulus.
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid32, valid64, st, gnt, rvalid;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;

  logic        a_ready, a_done, a_trap, a_req, a_wen;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_mask;
  logic        b_ready, b_done, b_trap, b_req, b_wen;
  logic [63:0] b_rdata, b_wdata;
  logic [31:0] b_addr;
  logic [7:0]  b_mask;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid32), .o_ready(a_ready),
    .i_store(st), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata[31:0]),
    .o_done(a_done), .o_rdata(a_rdata), .o_trap(a_trap), .o_mem_req(a_req),
    .i_mem_gnt(gnt), .o_mem_addr(a_addr), .o_mem_wen(a_wen), .o_mem_wdata(a_wdata),
    .o_mem_mask(a_mask), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata[31:0])
  );

  dmem_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(0)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid64), .o_ready(b_ready),
    .i_store(st), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
    .o_done(b_done), .o_rdata(b_rdata), .o_trap(b_trap), .o_mem_req(b_req),
    .i_mem_gnt(gnt), .o_mem_addr(b_addr), .o_mem_wen(b_wen), .o_mem_wdata(b_wdata),
    .o_mem_mask(b_mask), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: land just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; valid32 = 1'b0; valid64 = 1'b0; st = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    f3 = 3'b000; addr = 32'h0; wdata = 64'h0; rdata = 64'h0;
    #12;
    chk("rst_ready32", a_ready, 1);
    chk("rst_done32", a_done, 0);
    chk("rst_req32", a_req, 0);
    chk("rst_rdata32", a_rdata, 0);
    chk("rst_trap32", a_trap, 0);
    chk("rst_ready64", b_ready, 1);
    chk("rst_req64", b_req, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // 1: misaligned sw traps, no request, done two cycles after accept
    valid32 = 1'b1; st = 1'b1; f3 = F3_W; addr = 32'h1006; wdata = 64'h55;
    step(); valid32 = 1'b0;
    chk("t1_req_c1", a_req, 0);
    chk("t1_done_c1", a_done, 0);
    step();
    chk("t1_done_c2", a_done, 1);
    chk("t1_trap", a_trap, 1);
    chk("t1_req_c2", a_req, 0);
    chk("t1_rdata", a_rdata, 0);
    step();
    chk("t1_done_c3", a_done, 0);
    chk("t1_ready_c3", a_ready, 1);

    // 2: sb 0xAB at 0x2003, grant after 3 waiting cycles
    valid32 = 1'b1; st = 1'b1; f3 = F3_B; addr = 32'h2003; wdata = 64'hAB;
    step(); valid32 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t2_req_c%0d", c), a_req, 1);
      chk($sformatf("t2_addr_c%0d", c), a_addr, 32'h2000);
      if (c == 4) gnt = 1'b1;
      else        gnt = 1'b0;
      step();
    end
    gnt = 1'b0;
    chk("t2_mask", a_mask, 4'b1000);
    chk("t2_wdata", a_wdata, 32'hAB000000);
    chk("t2_wen", a_wen, 1);
    chk("t2_done", a_done, 1);
    chk("t2_trap", a_trap, 0);
    chk("t2_req_off", a_req, 0);
    step();

    // 3a: lh at 0x1002, response two cycles after grant
    valid32 = 1'b1; st = 1'b0; f3 = F3_H; addr = 32'h1002;
    step(); valid32 = 1'b0;
    chk("t3_mask", a_mask, 4'b1100);
    chk("t3_wen", a_wen, 0);
    gnt = 1'b1;
    step(); gnt = 1'b0;
    chk("t3_req_resp", a_req, 0);
    step();
    rvalid = 1'b1; rdata = 64'h80FF1234;
    step(); rvalid = 1'b0;
    chk("t3_lh_done", a_done, 1);
    chk("t3_lh_rdata", a_rdata, 32'hFFFF80FF);
    chk("t3_lh_trap", a_trap, 0);
    step();

    // 3b: lhu, stray rvalid in the grant cycle is ignored
    valid32 = 1'b1; f3 = F3_HU; addr = 32'h1002;
    step(); valid32 = 1'b0;
    gnt = 1'b1; rvalid = 1'b1; rdata = 64'hFFFFFFFF;
    step(); gnt = 1'b0;
    chk("t3_lhu_nodone_c2", a_done, 0);
    rdata = 64'h80FF1234;
    step(); rvalid = 1'b0;
    chk("t3_lhu_done", a_done, 1);
    chk("t3_lhu_rdata", a_rdata, 32'h000080FF);
    step();

    // 4: 64-bit ld / lwu / lw, then funct3 011 on the 32-bit unit
    valid64 = 1'b1; f3 = F3_D; addr = 32'h10;
    step(); valid64 = 1'b0;
    chk("t4_ld_addr", b_addr, 32'h10);
    chk("t4_ld_mask", b_mask, 8'hFF);
    gnt = 1'b1;
    step(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 64'h0123456789ABCDEF;
    step(); rvalid = 1'b0;
    chk("t4_ld_done", b_done, 1);
    chk("t4_ld_rdata", b_rdata, 64'h0123456789ABCDEF);
    step();
    valid64 = 1'b1; f3 = F3_WU; addr = 32'h14;
    step(); valid64 = 1'b0;
    chk("t4_lwu_addr", b_addr, 32'h10);
    chk("t4_lwu_mask", b_mask, 8'hF0);
    gnt = 1'b1;
    step(); gnt = 1'b0;
    rvalid = 1'b1;
    step(); rvalid = 1'b0;
    chk("t4_lwu_rdata", b_rdata, 64'h0000000001234567);
    step();
    valid64 = 1'b1; f3 = F3_W; addr = 32'h10;
    step(); valid64 = 1'b0;
    gnt = 1'b1;
    step(); gnt = 1'b0;
    rvalid = 1'b1;
    step(); rvalid = 1'b0;
    chk("t4_lw_rdata", b_rdata, 64'hFFFFFFFF89ABCDEF);
    step();
    valid32 = 1'b1; f3 = F3_D; addr = 32'h0;
    step(); valid32 = 1'b0;
    chk("t4_d32_req", a_req, 0);
    step();
    chk("t4_d32_done", a_done, 1);
    chk("t4_d32_trap", a_trap, 1);
    step();

    // 5: grant but no response -> timeout trap 8 cycles after accept
    valid32 = 1'b1; f3 = F3_W; addr = 32'h3000;
    step(); valid32 = 1'b0;
    gnt = 1'b1;
    step(); gnt = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      chk($sformatf("t5_wait_c%0d", c), a_done, 0);
      step();
    end
    chk("t5_done_c8", a_done, 1);
    chk("t5_trap", a_trap, 1);
    chk("t5_req", a_req, 0);
    chk("t5_rdata", a_rdata, 0);
    rvalid = 1'b1; rdata = 64'h12345678;
    step();
    chk("t5_ready_c9", a_ready, 1);
    step(); rvalid = 1'b0;
    chk("t5_stray_done", a_done, 0);
    step();

    // 6: reset during RESP, then a normal store
    valid32 = 1'b1; f3 = F3_W; addr = 32'h4000;
    step(); valid32 = 1'b0;
    gnt = 1'b1;
    step(); gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_req_rst", a_req, 0);
    chk("t6_ready_rst", a_ready, 1);
    chk("t6_done_rst", a_done, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    valid32 = 1'b1; st = 1'b1; f3 = F3_W; addr = 32'h4004; wdata = 64'h11223344;
    step(); valid32 = 1'b0;
    chk("t6_sw_req", a_req, 1);
    chk("t6_sw_wdata", a_wdata, 32'h11223344);
    chk("t6_sw_mask", a_mask, 4'b1111);
    gnt = 1'b1;
    step(); gnt = 1'b0;
    chk("t6_sw_done", a_done, 1);
    chk("t6_sw_trap", a_trap, 0);
    step();
    chk("t6_idle_done", a_done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
